// File: rtl/ps2_pkg.sv
// ps2_pkg: constants shared by the PS/2 host transmitter and the PS/2 receiver.
//   ST_*      host transmitter FSM state encodings
//   PS2_BITS  bits per PS/2 frame (start, 8 data, parity, stop)
//   CNT_W     width of the shared inhibit/timeout counter
//   odd_parity()  parity bit that makes the total count of ones (data + parity) odd
package ps2_pkg;

    localparam int PS2_BITS = 11;
    localparam int CNT_W    = 20;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: CPU-side command handshake of the PS/2 host transmitter.
//   tx_data     byte to send
//   tx_start    1-cycle send request
//   tx_ready    transmitter idle
//   tx_done     1-cycle pulse, frame acknowledged by the device
//   tx_err      1-cycle pulse, timeout or missing ACK
//   rx_inhibit  frame in progress; the receiver ignores the lines
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       rx_inhibit;

    modport master (output tx_data, tx_start,
                    input  tx_ready, tx_done, tx_err, rx_inhibit);

    modport slave  (input  tx_data, tx_start,
                    output tx_ready, tx_done, tx_err, rx_inhibit);

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pad input.
//   clki    system clock
//   rst_in  synchronous active-low reset
//   line_i  raw asynchronous pad input
//   filt    synchronized line, changes only after FILTER_LEN consecutive differing samples
//   fall    1-cycle pulse, coincident with filt going 1 -> 0
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clki,
    input  logic rst_in,
    input  logic line_i,
    output logic filt,
    output logic fall
);

    localparam int RW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [RW-1:0] run;

    always_ff @(posedge clki) begin
        if (!rst_in) begin
            sync <= 2'b11;      // idle PS/2 lines float high
            filt <= 1'b1;
            run  <= '0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], line_i};
            fall <= 1'b0;
            if (sync[1] == filt) begin
                run <= '0;
            end else if (run == RW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                run  <= '0;
                fall <= filt;   // old value 1 means this is a falling transition
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter, sends one command byte to the keyboard.
//   clki         system clock
//   rst_in       synchronous active-low reset
//   bus          command handshake (tx_data/tx_start in, tx_ready/tx_done/tx_err/rx_inhibit out)
//   ps2_clk_i    raw ps2_clk pad input
//   ps2_data_i   raw ps2_data pad input
//   ps2_clk_oe   1 = pull ps2_clk low
//   ps2_data_oe  1 = pull ps2_data low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000,
    parameter int FILTER_LEN  = 8
) (
    input  logic          clki,
    input  logic          rst_in,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam logic [3:0] LAST_BIT = 4'(PS2_BITS - 2);   // stop bit index

    logic             clk_filt, clk_fall, data_filt, data_fall_unused;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       sh;
    logic             par;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clki(clki), .rst_in(rst_in), .line_i(ps2_clk_i),
        .filt(clk_filt), .fall(clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clki(clki), .rst_in(rst_in), .line_i(ps2_data_i),
        .filt(data_filt), .fall(data_fall_unused)
    );

    always_ff @(posedge clki) begin
        if (!rst_in) begin
            state          <= ST_IDLE;
            bus.tx_ready   <= 1'b1;
            bus.tx_done    <= 1'b0;
            bus.tx_err     <= 1'b0;
            bus.rx_inhibit <= 1'b0;
            ps2_clk_oe     <= 1'b0;
            ps2_data_oe    <= 1'b0;
            cnt            <= '0;
            bit_cnt        <= '0;
            sh             <= '0;
            par            <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            bus.tx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.tx_start && bus.tx_ready) begin
                        sh             <= bus.tx_data;
                        par            <= odd_parity(bus.tx_data);
                        bit_cnt        <= '0;
                        cnt            <= '0;
                        ps2_clk_oe     <= 1'b1;
                        bus.tx_ready   <= 1'b0;
                        bus.rx_inhibit <= 1'b1;
                        state          <= ST_INHIBIT;
                    end else begin
                        // ready rises one cycle after a done/err pulse
                        bus.tx_ready   <= 1'b1;
                        bus.rx_inhibit <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
                        ps2_data_oe <= 1'b1;        // start bit
                        state       <= ST_RTS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RTS: begin
                    ps2_clk_oe <= 1'b0;             // hand the clock to the device
                    cnt        <= '0;
                    state      <= ST_SEND;
                end
                default: begin
                    // SEND / ACK / WAIT_IDLE share the timeout; it wins over a same-cycle fall
                    if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        ps2_clk_oe     <= 1'b0;
                        ps2_data_oe    <= 1'b0;
                        bus.tx_err     <= 1'b1;
                        bus.rx_inhibit <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        case (state)
                            ST_SEND: if (clk_fall) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt < 4'd8) begin
                                    ps2_data_oe <= ~sh[0];
                                    sh          <= {1'b0, sh[7:1]};
                                end else if (bit_cnt != LAST_BIT) begin
                                    ps2_data_oe <= ~par;
                                end else begin
                                    ps2_data_oe <= 1'b0;    // stop bit: release
                                    state       <= ST_ACK;
                                end
                            end
                            ST_ACK: if (clk_fall) begin
                                if (!data_filt) begin
                                    state <= ST_WAIT_IDLE;
                                end else begin
                                    bus.tx_err     <= 1'b1;
                                    bus.rx_inhibit <= 1'b0;
                                    state          <= ST_IDLE;
                                end
                            end
                            ST_WAIT_IDLE: if (clk_filt && data_filt) begin
                                bus.tx_done    <= 1'b1;
                                bus.rx_inhibit <= 1'b0;
                                state          <= ST_IDLE;
                            end
                            default: begin
                                bus.rx_inhibit <= 1'b0;
                                state          <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-side PS/2 model drives the clock and samples the data line,
// frames are compared against the 11-bit frame rule computed from the byte.
module tb_ps2_host_tx;

    localparam int HALF = 20;   // device clock half-period in system cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic ps2_clk_line, ps2_data_line;
    assign ps2_clk_line  = ~((ps2_clk_oe === 1'b1) | dev_clk_low);
    assign ps2_data_line = ~((ps2_data_oe === 1'b1) | dev_data_low);

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYC(50), .TIMEOUT_CYC(4000), .FILTER_LEN(2)) dut (
        .clki(clk), .rst_in(rst_n), .bus(bus),
        .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, clo_cnt = 0;

    always @(negedge clk) begin
        if (bus.tx_done === 1'b1) done_cnt++;
        if (bus.tx_err === 1'b1) err_cnt++;
        if (bus.tx_done === 1'b1 && bus.tx_err === 1'b1) both_cnt++;
        if (ps2_clk_oe === 1'b1) clo_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe !== 1'b1) inh_cnt++;
    end

    // frame as the device sees it: start, d0..d7, odd parity, stop
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] b);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.tx_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL ready_wait: tx_ready=%b required 1", bus.tx_ready); end
        bus.tx_data = b; bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_release();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (ps2_clk_oe === 1'b0) begin ok = 1; break; end
            @(negedge clk);
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL clk_release: clk_oe=%b required 0", ps2_clk_oe); end
    endtask

    task automatic dev_clock(input int nfalls, input bit ack, input bit glitch, output logic [10:0] s);
        s = '1;
        for (int k = 0; k < nfalls; k++) begin
            repeat (HALF/2) @(negedge clk);
            if (glitch && k == 4) begin dev_clk_low = 1'b1; @(negedge clk); dev_clk_low = 1'b0; end
            repeat (HALF/2) @(negedge clk);
            s[k] = ps2_data_line;
            if (k == 10 && ack) begin dev_data_low = 1'b1; repeat (8) @(negedge clk); end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (4) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit glitch, input bit mid_start,
                             output logic [10:0] s, output int dn, output int er, output int inh, output int clo);
        int d0 = done_cnt, e0 = err_cnt, i0 = inh_cnt, c0 = clo_cnt;
        start_tx(b);
        if (mid_start) begin
            repeat (10) @(negedge clk);
            bus.tx_data = ~b; bus.tx_start = 1'b1;
            @(negedge clk);
            bus.tx_start = 1'b0;
        end
        wait_release();
        dev_clock(11, ack, glitch, s);
        repeat (40) @(negedge clk);
        dn = done_cnt - d0; er = err_cnt - e0; inh = inh_cnt - i0; clo = clo_cnt - c0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk += 6;
        if (bus.tx_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.tx_ready); end
        if (bus.tx_done !== 1'b0)    begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.tx_done); end
        if (bus.tx_err !== 1'b0)     begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.tx_err); end
        if (bus.rx_inhibit !== 1'b0) begin n_fail++; $display("FAIL rst_inhibit: got %b want 0", bus.rx_inhibit); end
        if (ps2_clk_oe !== 1'b0)     begin n_fail++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
        if (ps2_data_oe !== 1'b0)    begin n_fail++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_led_cmd();
        logic [10:0] s, e;
        int dn, er, inh, clo;
        e = exp_frame(8'hED);
        run_frame(8'hED, 1, 0, 0, s, dn, er, inh, clo);
        n_chk += 6;
        if (s !== e)  begin n_fail++; $display("FAIL led_bits: got %b want %b", s, e); end
        if (inh != 50) begin n_fail++; $display("FAIL led_inhibit_len: got %0d want 50", inh); end
        if (clo != 51) begin n_fail++; $display("FAIL led_clk_oe_len: got %0d want 51", clo); end
        if (dn != 1)  begin n_fail++; $display("FAIL led_done: got %0d want 1", dn); end
        if (er != 0)  begin n_fail++; $display("FAIL led_err: got %0d want 0", er); end
        if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL led_ready: got %b want 1", bus.tx_ready); end
    endtask

    task automatic test_parity();
        logic [7:0] bytes [5];
        logic [10:0] s, e;
        int dn, er, inh, clo;
        bytes[0] = 8'hFF; bytes[1] = 8'h00;
        for (int i = 2; i < 5; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            e = exp_frame(bytes[i]);
            run_frame(bytes[i], 1, 0, 0, s, dn, er, inh, clo);
            n_chk += 4;
            if (s[9] !== e[9])  begin n_fail++; $display("FAIL parity_%02h: got %b want %b", bytes[i], s[9], e[9]); end
            if (s[10] !== 1'b1) begin n_fail++; $display("FAIL stop_%02h: got %b want 1", bytes[i], s[10]); end
            if (s !== e)        begin n_fail++; $display("FAIL frame_%02h: got %b want %b", bytes[i], s, e); end
            if (dn != 1 || er != 0) begin n_fail++; $display("FAIL status_%02h: done=%0d err=%0d want 1/0", bytes[i], dn, er); end
        end
    endtask

    task automatic test_timeout();
        int lat = 0, d0 = done_cnt;
        bit seen = 0;
        start_tx(8'($urandom));
        wait_release();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            lat++;
            if (bus.tx_err === 1'b1) begin seen = 1; break; end
        end
        n_chk += 4;
        if (!seen || lat < 3999 || lat > 4001) begin n_fail++; $display("FAIL timeout_lat: seen=%0d cycles=%0d want 4000", seen, lat); end
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            n_fail++; $display("FAIL timeout_oe: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe);
        end
        @(negedge clk);
        if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got %b want 1", bus.tx_ready); end
        if (done_cnt != d0) begin n_fail++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_no_ack();
        logic [7:0] b = 8'($urandom);
        logic [10:0] s, e;
        int dn, er, inh, clo;
        e = exp_frame(b);
        run_frame(b, 0, 0, 0, s, dn, er, inh, clo);
        n_chk += 3;
        if (s[9:0] !== e[9:0]) begin n_fail++; $display("FAIL noack_bits: got %b want %b", s[9:0], e[9:0]); end
        if (er != 1) begin n_fail++; $display("FAIL noack_err: got %0d want 1", er); end
        if (dn != 0) begin n_fail++; $display("FAIL noack_done: got %0d want 0", dn); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'($urandom) & 8'hEF;   // d4=0 so the host is pulling data low
        logic [10:0] s, e;
        int dn, er, inh, clo;
        start_tx(b);
        wait_release();
        dev_clock(5, 0, 0, s);
        n_chk += 5;
        if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL mid_pre_data_oe: got %b want 1", ps2_data_oe); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL mid_data_oe: got %b want 0", ps2_data_oe); end
        if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL mid_clk_oe: got %b want 0", ps2_clk_oe); end
        if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", bus.tx_ready); end
        if (bus.rx_inhibit !== 1'b0) begin n_fail++; $display("FAIL mid_inhibit: got %b want 0", bus.rx_inhibit); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        e = exp_frame(8'h07);
        run_frame(8'h07, 1, 0, 0, s, dn, er, inh, clo);
        n_chk += 3;
        if (s[9] !== 1'b0) begin n_fail++; $display("FAIL after_rst_parity: got %b want 0", s[9]); end
        if (s !== e) begin n_fail++; $display("FAIL after_rst_bits: got %b want %b", s, e); end
        if (dn != 1 || er != 0) begin n_fail++; $display("FAIL after_rst_status: done=%0d err=%0d want 1/0", dn, er); end
    endtask

    task automatic test_ignore_start();
        logic [10:0] s, e;
        int dn, er, inh, clo;
        e = exp_frame(8'h3C);
        run_frame(8'h3C, 1, 1, 1, s, dn, er, inh, clo);
        n_chk += 3;
        if (s !== e) begin n_fail++; $display("FAIL ignore_bits: got %b want %b", s, e); end
        if (dn != 1 || er != 0) begin n_fail++; $display("FAIL ignore_status: done=%0d err=%0d want 1/0", dn, er); end
        if (clo != 51) begin n_fail++; $display("FAIL ignore_clk_oe_len: got %0d want 51", clo); end
    endtask

    initial begin
        bus.tx_data = 8'h00;
        bus.tx_start = 1'b0;
        test_reset();
        test_led_cmd();
        test_parity();
        test_timeout();
        test_no_ack();
        test_reset_mid();
        test_ignore_start();
        n_chk++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
